mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter
Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  ADDR_W  9  word-address width
  DATA_W  32  data width
  RD_LAT  1  RAM read latency in cycles, legal 1..7
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  Clock  in  1  single clock; all state updates on the rising edge
  Reset  in  1  synchronous, active-high reset
  cpu_req  in  1  CPU requests an access (control unit Read/Write)
  cpu_we  in  1  1 = write, 0 = read
  cpu_addr  in  ADDR_W  CPU word address
  cpu_wdata  in  DATA_W  CPU write data
  cpu_ack  out  1  one-cycle completion pulse to CPU
  cpu_rdata  out  DATA_W  CPU read data, registered
  dbg_req  in  1  debug/loader port requests an access
  dbg_we  in  1  1 = write, 0 = read
  dbg_addr  in  ADDR_W  debug word address
  dbg_wdata  in  DATA_W  debug write data
  dbg_ack  out  1  one-cycle completion pulse to debug port
  dbg_rdata  out  DATA_W  debug read data, registered
  mem_en  out  1  RAM access strobe
  mem_we  out  1  RAM write enable
  mem_addr  out  ADDR_W  RAM address
  mem_wdata  out  DATA_W  RAM write data
  mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after mem_en
  cpu_gnt  out  1  CPU owns the RAM port
  dbg_gnt  out  1  debug port owns the RAM port
Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE, with transitions: IDLE->ISSUE when any req is sampled high; ISSUE->WAIT; WAIT->DONE after RD_LAT cycles (3-bit counter); DONE->IDLE unconditionally. One transaction SHALL be in flight at a time.
REQ-004 In IDLE, a single req SHALL win; simultaneous reqs SHALL be resolved per REQ-014/015. On the same edge the block SHALL latch the winner as owner, together with the winner's addr, we and wdata.
REQ-005 In ISSUE the block SHALL drive mem_en=1, mem_we=latched we and the latched addr/wdata for exactly one cycle; mem_en and mem_we SHALL be 0 in every other state.
REQ-006 On the last WAIT edge, a read SHALL register mem_rdata into the owner's rdata. A write SHALL leave rdata unchanged. The non-owner's rdata SHALL never change.
REQ-007 In DONE the owner's ack SHALL be 1 for exactly one cycle; the other ack SHALL be 0.
REQ-008 Latency: a req sampled at edge n SHALL produce ack high between edges n+1+RD_LAT and n+2+RD_LAT. The next request SHALL be sampled no earlier than edge n+3+RD_LAT, giving a period of 3+RD_LAT cycles.
REQ-009 The owner's gnt SHALL be 1 in ISSUE, WAIT and DONE; both gnt SHALL be 0 in IDLE and SHALL never both be 1.
REQ-010 Handshake: the requester holds req and its inputs stable until ack. Inputs SHALL be ignored after capture. If req drops mid-transaction, the access SHALL still complete and ack SHALL still pulse. A req still high in the IDLE cycle after DONE SHALL count as a new request.
REQ-011 RD_LAT outside 1..7 SHALL be unsupported.
Reset
REQ-012 Reset high at a rising edge SHALL force: state=IDLE; mem_en, mem_we, both ack, both gnt = 0; mem_addr, mem_wdata, cpu_rdata, dbg_rdata = 0; last-grant = dbg. Reset SHALL dominate all other inputs.
REQ-013 Reset mid-transaction SHALL abort it with no ack; a write already issued is not undone. The first sampling edge SHALL be the edge after Reset falls.
Configuration
REQ-014 With ARB_ROUND_ROBIN_EN defined, a tie SHALL go to the requester not granted last. last-grant SHALL update on every grant, so the CPU wins the first tie after reset.
REQ-015 With ARB_ROUND_ROBIN_EN undefined, the CPU SHALL always win ties (dbg may starve), and no last-grant register SHALL exist.
Verification
REQ-016 RD_LAT=1, RAM[0x005]=0x000000AB, cpu read 0x005 sampled at edge 0 -> one mem_en cycle with addr 0x005 and we=0; cpu_ack high between edges 2 and 3; cpu_rdata=0x000000AB; dbg_rdata=0.
REQ-017 dbg write 0x1FF=0xDEADBEEF, then cpu read 0x1FF -> cpu_rdata=0xDEADBEEF; dbg_rdata unchanged by the write.
REQ-018 Both reqs held for 4 transactions -> with the macro defined, grants cpu,dbg,cpu,dbg with acks 4 cycles apart; with it undefined, cpu,cpu,cpu,cpu and dbg_ack never asserts.
REQ-019 Reset asserted in WAIT of a cpu read -> no cpu_ack and all outputs 0 after that edge; the reissued read returns correct data.
REQ-020 RD_LAT=4, cpu read sampled at edge 0 -> cpu_ack high between edges 5 and 6; the next access is sampled at edge 7.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: cpu/debug arbiter, one transaction in flight to a sync RAM.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default: cpu wins ties.
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_gnt,
  output logic              dbg_gnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [2:0] LAST = 3'(RD_LAT - 1);

  logic [1:0] state;
  logic [2:0] cnt;
  logic       owner_dbg;
  logic       we_q;
  logic       win_dbg;
  logic       any_req;

  assign any_req = cpu_req | dbg_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dbg;

  // a tie goes to whoever was not granted last
  assign win_dbg = dbg_req & (~cpu_req | ~last_dbg);

  always_ff @(posedge Clock) begin
    if (Reset)
      last_dbg <= 1'b1;
    else if (state == IDLE && any_req)
      last_dbg <= win_dbg;
  end
`else
  assign win_dbg = dbg_req & ~cpu_req;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      owner_dbg <= 1'b0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ISSUE;
            owner_dbg <= win_dbg;
            we_q      <= win_dbg ? dbg_we : cpu_we;
            mem_addr  <= win_dbg ? dbg_addr : cpu_addr;
            mem_wdata <= win_dbg ? dbg_wdata : cpu_wdata;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= 3'd0;
        end
        WAIT: begin
          if (cnt == LAST) begin
            state <= DONE;
            if (!we_q) begin
              if (owner_dbg) dbg_rdata <= mem_rdata;
              else           cpu_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  assign mem_en  = (state == ISSUE);
  assign mem_we  = mem_en & we_q;
  assign cpu_gnt = (state != IDLE) & ~owner_dbg;
  assign dbg_gnt = (state != IDLE) & owner_dbg;
  assign cpu_ack = (state == DONE) & ~owner_dbg;
  assign dbg_ack = (state == DONE) & owner_dbg;

endmodule
